ofifo_col_bank: RTL and testbench
=================================

# ofifo_col_bank

Output FIFO bank at the south edge of the systolic MAC array. It holds one independent FIFO per array column and captures each column's partial sum whenever that column flags it valid. Because the columns finish on a diagonal skew, the bank realigns them and releases complete rows, one word per column, to the downstream accumulator/SRAM writer.

## Interface
- col, 8, number of array columns, i.e. FIFOs in the bank
- psum_bw, 16, width of one partial sum
- depth, 64, entries per column FIFO; power of two, ≥ 2
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- wr  input  col  per-column push strobe; bit i pushes column i
- in  input  col*psum_bw  column i data at bits [(i+1)*psum_bw-1 : i*psum_bw]
- rd  input  1  pop one full row
- out  output  col*psum_bw  popped row, same column packing as in
- out_vld  output  1  out holds a newly popped row this cycle
- o_valid  output  1  every column holds ≥ 1 entry; a row is available
- o_full  output  1  at least one column is full
- o_ready  output  1  equals !o_full
- o_overflow  output  1  sticky: a push to a full column was dropped

## Operation
- Per column: storage of depth × psum_bw; write and read pointers of log2(depth)+1 bits. Full when the low bits are equal and the MSBs differ. Empty when the pointers are equal. Pointers wrap modulo 2·depth.
- Push: wr[i]=1 and column i not full at the start of the cycle. The slice is written at wptr[i] and wptr[i] is incremented.
- Push to a full column: dropped, no pointer change, o_overflow set to 1. This holds even if a pop is accepted in the same cycle; fullness is judged from registered state only.
- o_valid = AND over all columns of !empty, taken from registered pointers. A push in cycle N makes data visible to o_valid in cycle N+1.
- Pop accepted: rd=1 and o_valid=1. Every column's rptr is incremented. The entries at the old rptr values are registered into out.
- rd with o_valid=0: ignored. No pointer change, out holds its value, out_vld=0. Not an error.
- Simultaneous push and pop on a non-full column are both performed. Occupancy is unchanged.
- Columns are independent. Occupancy may differ by any amount up to depth.
- o_overflow is cleared only by reset.

## Timing
- Reset (synchronous): all pointers 0, out=0, out_vld=0, o_overflow=0. This gives o_valid=0, o_full=0, o_ready=1. Storage contents are not reset.
- Reset asserted mid-operation discards all queued data on the next edge. Pushes and pops in the reset cycle are ignored.
- Pop latency is 1 cycle. rd accepted at edge N gives out and out_vld=1 valid after edge N, for one cycle. out holds its value afterwards; out_vld returns to 0 unless another pop is accepted.
- Back-to-back pops are allowed every cycle while o_valid=1, giving a throughput of 1 row per cycle.
- o_full, o_ready and o_valid are pure functions of registered pointers, with no combinational path from wr or rd.
- Push-to-pop minimum: a push at edge N (last column to fill) gives o_valid=1 after edge N; a pop at N+1 gives out after N+1.

## Test plan
- Reset, then no activity: o_valid=0, o_full=0, o_ready=1, out=0, out_vld=0, o_overflow=0.
- Skewed fill, col=8: push column i with value 0x0100+i at cycle i (i=0..7). o_valid=0 through cycle 7 and 1 after the cycle-7 edge. rd at the next cycle gives out_vld=1 with out column i = 0x0100+i, after which o_valid=0.
- Ordering and wrap, depth=64: push 100 rows with value r·16+i and pop concurrently, keeping occupancy ≤ 8. Every popped row matches in order and pointers wrap cleanly.
- Full and overflow: push column 3 only, 64 times. o_full=1 and o_ready=0 after the 64th. A 65th push with value 0xDEAD is dropped and o_overflow=1. Fill the other columns, then pop 64 rows: 0xDEAD never appears and o_overflow stays 1.
- Push to a full column while popping: with all columns full, assert rd and wr[0] together. The row is popped, the column-0 write is dropped, and o_overflow=1.
- Underflow and mid-run reset: rd with column 5 empty gives out_vld=0 and out unchanged. With 10 rows queued, assert reset for 1 cycle: o_valid=0, out=0, and a subsequent single-row fill returns only the new data.

Source files
------------

// File: rtl/ofifo_col_bank.sv
// Output FIFO bank for the systolic array south edge: one FIFO per column,
// released as complete rows once every column holds at least one entry.
module ofifo_col_bank #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [col-1:0]         wr,
   input  logic [col*psum_bw-1:0] in,
   input  logic                   rd,
   output logic [col*psum_bw-1:0] out,
   output logic                   out_vld,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_ready,
   output logic                   o_overflow
);

   localparam int aw = $clog2(depth);

   logic [col-1:0]     full_c;
   logic [col-1:0]     empty_c;
   logic [col-1:0]     push;
   logic [psum_bw-1:0] rd_data [col];
   logic               pop;

   // Flags come only from registered pointers, so no wr/rd path reaches them.
   assign o_valid = ~|empty_c;
   assign o_full  = |full_c;
   assign o_ready = ~o_full;
   assign pop     = rd & o_valid;

   for (genvar i = 0; i < col; i++) begin : g_col
      logic [psum_bw-1:0] mem [depth];
      logic [aw:0]        wptr;
      logic [aw:0]        rptr;

      assign full_c[i]  = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);
      assign empty_c[i] = (wptr == rptr);
      assign push[i]    = wr[i] & ~full_c[i];
      assign rd_data[i] = mem[rptr[aw-1:0]];

      always_ff @(posedge clk) begin
         if (push[i] && !reset)
            mem[wptr[aw-1:0]] <= in[i*psum_bw +: psum_bw];
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (push[i])
               wptr <= wptr + (aw+1)'(1);
            if (pop)
               rptr <= rptr + (aw+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out        <= '0;
         out_vld    <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         out_vld <= pop;
         if (pop) begin
            for (int i = 0; i < col; i++)
               out[i*psum_bw +: psum_bw] <= rd_data[i];
         end
         // Drops are judged against pre-edge fullness, even when a pop frees space.
         if (|(wr & full_c))
            o_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ofifo_col_bank.sv
// Scoreboard bench for ofifo_col_bank: per-column queue model, expected rows
// queued at issue time and compared by a monitor whenever out_vld is seen.
module tb_ofifo_col_bank;

   localparam int col     = 8;
   localparam int psum_bw = 16;
   localparam int depth   = 64;
   localparam int w_all   = col*psum_bw;

   logic               clk = 1'b0;
   logic               reset;
   logic [col-1:0]     wr;
   logic [w_all-1:0]   in;
   logic               rd;
   logic [w_all-1:0]   out;
   logic               out_vld;
   logic               o_valid;
   logic               o_full;
   logic               o_ready;
   logic               o_overflow;

   int checks = 0;
   int errors = 0;

   logic [psum_bw-1:0] mq [col][$];
   logic [w_all-1:0]   exp_q [$];
   logic [w_all-1:0]   last_out;
   logic               m_ovf;
   logic               exp_vld;
   int                 pops_done;

   ofifo_col_bank #(.col(col), .psum_bw(psum_bw), .depth(depth)) dut (
      .clk(clk), .reset(reset), .wr(wr), .in(in), .rd(rd), .out(out),
      .out_vld(out_vld), .o_valid(o_valid), .o_full(o_full),
      .o_ready(o_ready), .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [w_all-1:0] act, input logic [w_all-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every delivered row must be the oldest outstanding expected row.
   always @(negedge clk) begin
      if (out_vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_row: got %h expected none", out);
         end else begin
            chk("row_data", out, exp_q.pop_front());
         end
      end
   end

   function automatic logic model_valid();
      for (int i = 0; i < col; i++)
         if (mq[i].size() == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic model_full();
      for (int i = 0; i < col; i++)
         if (mq[i].size() == depth) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [w_all-1:0] rand_row();
      logic [w_all-1:0] v;
      for (int i = 0; i < col; i++)
         v[i*psum_bw +: psum_bw] = psum_bw'($urandom);
      return v;
   endfunction

   // One clock: drive, advance model, then check flags after the edge.
   task automatic step(input logic [col-1:0] w, input logic [w_all-1:0] d,
                       input logic r, input logic rst);
      logic [col-1:0]   full_now;
      logic [w_all-1:0] row;
      wr = w; in = d; rd = r; reset = rst;
      if (rst) begin
         for (int i = 0; i < col; i++) mq[i].delete();
         m_ovf = 1'b0;
         last_out = '0;
         exp_vld = 1'b0;
      end else begin
         for (int i = 0; i < col; i++) full_now[i] = (mq[i].size() == depth);
         exp_vld = r && model_valid();
         if (exp_vld) begin
            for (int i = 0; i < col; i++) row[i*psum_bw +: psum_bw] = mq[i].pop_front();
            exp_q.push_back(row);
            last_out = row;
            pops_done++;
         end
         for (int i = 0; i < col; i++) begin
            if (w[i]) begin
               if (full_now[i]) m_ovf = 1'b1;
               else mq[i].push_back(d[i*psum_bw +: psum_bw]);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      chk("o_valid", w_all'(o_valid), w_all'(model_valid()));
      chk("o_full", w_all'(o_full), w_all'(model_full()));
      chk("o_ready", w_all'(o_ready), w_all'(!model_full()));
      chk("o_overflow", w_all'(o_overflow), w_all'(m_ovf));
      chk("out_vld", w_all'(out_vld), w_all'(exp_vld));
      if (!exp_vld) chk("out_hold", out, last_out);
   endtask

   task automatic idle();
      step('0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [w_all-1:0] d;
      logic [col-1:0]   w;
      int               nxt [col];
      int               budget;
      last_out = '0; m_ovf = 1'b0; exp_vld = 1'b0; pops_done = 0;
      wr = '0; in = '0; rd = 1'b0; reset = 1'b1;

      // Reset and idle
      step('0, '0, 1'b0, 1'b1);
      step('0, '0, 1'b0, 1'b1);
      repeat (2) idle();
      chk("reset_out", out, '0);

      // Skewed fill, one column per cycle, then a single row pop
      for (int i = 0; i < col; i++) begin
         d = '0;
         d[i*psum_bw +: psum_bw] = psum_bw'(16'h0100 + i);
         step(col'(1) << i, d, 1'b0, 1'b0);
      end
      chk("skew_valid", w_all'(o_valid), w_all'(1));
      step('0, '0, 1'b1, 1'b0);
      chk("skew_row_out", out, {16'h0107, 16'h0106, 16'h0105, 16'h0104,
                                16'h0103, 16'h0102, 16'h0101, 16'h0100});

      // Ordering and pointer wrap: 100 rows, occupancy capped at 8
      for (int i = 0; i < col; i++) nxt[i] = 0;
      pops_done = 0;
      budget = 0;
      while (pops_done < 100 && budget < 3000) begin
         w = '0; d = '0;
         for (int i = 0; i < col; i++) begin
            if (nxt[i] < 100 && mq[i].size() < 8 && $urandom_range(0, 3) != 0) begin
               w[i] = 1'b1;
               d[i*psum_bw +: psum_bw] = psum_bw'(nxt[i]*16 + i);
               nxt[i]++;
            end
         end
         step(w, d, 1'($urandom_range(0, 1)), 1'b0);
         budget++;
      end
      chk("wrap_rows_done", w_all'(pops_done), w_all'(100));
      idle();

      // Full and overflow on column 3
      step('0, '0, 1'b0, 1'b1);
      for (int k = 0; k < depth; k++) step(8'h08, rand_row(), 1'b0, 1'b0);
      chk("col3_full", w_all'({o_full, o_ready}), w_all'(2'b10));
      d = rand_row();
      d[3*psum_bw +: psum_bw] = 16'hDEAD;
      step(8'h08, d, 1'b0, 1'b0);
      for (int k = 0; k < depth; k++) step(8'hF7, rand_row(), 1'b0, 1'b0);
      for (int k = 0; k < depth; k++) step('0, '0, 1'b1, 1'b0);
      idle();
      chk("ovf_sticky", w_all'(o_overflow), w_all'(1));

      // Push to a full column while popping
      step('0, '0, 1'b0, 1'b1);
      for (int k = 0; k < depth; k++) step('1, rand_row(), 1'b0, 1'b0);
      step(8'h01, rand_row(), 1'b1, 1'b0);
      idle();

      // Underflow with column 5 empty
      step('0, '0, 1'b0, 1'b1);
      step(8'hDF, rand_row(), 1'b0, 1'b0);
      step(8'hDF, rand_row(), 1'b0, 1'b0);
      step(8'h20, rand_row(), 1'b0, 1'b0);
      step('0, '0, 1'b1, 1'b0);
      d = out;
      step(8'h00, '0, 1'b1, 1'b0);
      chk("underflow_ignored", w_all'(out_vld), w_all'(0));
      chk("underflow_out_held", out, d);

      // Mid-run reset with 10 rows queued, then a single fresh row
      for (int k = 0; k < 10; k++) step('1, rand_row(), 1'b0, 1'b0);
      step('1, rand_row(), 1'b1, 1'b1);
      chk("reset_out_zero", out, '0);
      d = rand_row();
      step('1, d, 1'b0, 1'b0);
      step('0, '0, 1'b1, 1'b0);
      chk("post_reset_row", out, d);
      idle();
      chk("post_reset_empty", w_all'(o_valid), w_all'(0));

      // Random traffic
      for (int k = 0; k < 600; k++)
         step(col'($urandom), rand_row(), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 199) == 0));
      idle();
      idle();

      chk("scoreboard_drained", w_all'(exp_q.size()), w_all'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
